ipu_frame_ctrl: RTL and testbench

//  Frame sequencer between the image processing unit pixel stream and its sinks (VGA driver, dumper).

---
 rtl/ipu_frame_ctrl.sv | 114 +++++++++++
 tb/tb_ipu_frame_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipu_frame_ctrl.sv
// Frame sequencer gating the IPU pixel stream into whole IMG_WIDTH x IMG_HEIGHT frames.
// Latency: zero, with combinational pass-through of data, valid and ready.
// Backpressure: downstream ready feeds upstream ready while the gate is open. Outside RUN/DRAIN both sides are stalled.
module ipu_frame_ctrl #(
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [FRAME_CNT_W-1:0]        frames_req,
    input  logic                          s_pixel_valid,
    output logic                          s_pixel_ready,
    input  logic [23:0]                   s_pixel_data,
    output logic                          m_pixel_valid,
    input  logic                          m_pixel_ready,
    output logic [23:0]                   m_pixel_data,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          m_eof,
    output logic [$clog2(IMG_WIDTH)-1:0]  x_pos,
    output logic [$clog2(IMG_HEIGHT)-1:0] y_pos,
    output logic                          busy,
    output logic                          done,
    output logic [FRAME_CNT_W-1:0]        frames_done
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [FRAME_CNT_W-1:0] req_q;
    logic [FRAME_CNT_W-1:0] frames_inc;
    logic                   beat;
    logic                   x_last;
    logic                   y_last;
    logic                   eof_beat;

    // busy is registered as exactly (state == RUN || state == DRAIN), so it is the gate
    assign m_pixel_valid = s_pixel_valid & busy;
    assign s_pixel_ready = m_pixel_ready & busy;
    assign m_pixel_data  = s_pixel_data;
    assign beat          = m_pixel_valid & m_pixel_ready;

    assign x_last     = (x_pos == XW'(IMG_WIDTH - 1));
    assign y_last     = (y_pos == YW'(IMG_HEIGHT - 1));
    assign m_sof      = m_pixel_valid & (x_pos == '0) & (y_pos == '0);
    assign m_eol      = m_pixel_valid & x_last;
    assign m_eof      = m_pixel_valid & x_last & y_last;
    assign eof_beat   = beat & x_last & y_last;
    assign frames_inc = frames_done + FRAME_CNT_W'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            frames_done <= '0;
            req_q       <= '0;
        end else begin
            done <= 1'b0;
            if (beat) begin
                if (x_last) begin
                    x_pos <= '0;
                    y_pos <= y_last ? '0 : y_pos + YW'(1);
                end else begin
                    x_pos <= x_pos + XW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        req_q       <= frames_req;
                        frames_done <= '0;
                        x_pos       <= '0;
                        y_pos       <= '0;
                    end
                end
                RUN: begin
                    if (eof_beat) begin
                        frames_done <= frames_inc;
                        if (stop || (req_q != '0 && frames_inc == req_q)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (eof_beat) begin
                        frames_done <= frames_inc;
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipu_frame_ctrl.sv
// Directed bench for ipu_frame_ctrl with 8x8 frames.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
module tb_ipu_frame_ctrl;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        stop;
    logic [7:0]  frames_req;
    logic        s_pixel_valid;
    logic        s_pixel_ready;
    logic [23:0] s_pixel_data;
    logic        m_pixel_valid;
    logic        m_pixel_ready;
    logic [23:0] m_pixel_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic [2:0]  x_pos;
    logic [2:0]  y_pos;
    logic        busy;
    logic        done;
    logic [7:0]  frames_done;

    ipu_frame_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .FRAME_CNT_W(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .stop(stop), .frames_req(frames_req),
        .s_pixel_valid(s_pixel_valid), .s_pixel_ready(s_pixel_ready), .s_pixel_data(s_pixel_data),
        .m_pixel_valid(m_pixel_valid), .m_pixel_ready(m_pixel_ready), .m_pixel_data(m_pixel_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .done(done), .frames_done(frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // results of the most recent run() call
    int beats, done_cnt, done_cyc, eof_cyc, done_lat;
    int sof_cnt, eol_cnt, eof_cnt;
    int pos_bad, mark_bad, data_bad, done_gate_bad;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] req);
        @(negedge clk);
        s_pixel_valid = 1'b0;
        start         = 1'b1;
        frames_req    = req;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams beats until one cycle-budget runs out or done has been seen.
    // Expected marker, position and data values come from the beat index.
    task automatic run(input int max_cyc, input bit rnd, input int stop_beat);
        int b;
        beats = 0; done_cnt = 0; done_cyc = -1; eof_cyc = -1; done_lat = -1;
        sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
        pos_bad = 0; mark_bad = 0; data_bad = 0; done_gate_bad = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            s_pixel_data  = 24'(beats + 256);
            s_pixel_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop          = (stop_beat >= 0) && (beats == stop_beat);
            #1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    done_lat = c - eof_cyc;
                end
                if (m_pixel_valid || s_pixel_ready) done_gate_bad++;
            end
            if (m_pixel_valid && m_pixel_ready) begin
                b = beats % 64;
                if (x_pos != 3'(b % 8) || y_pos != 3'(b / 8)) pos_bad++;
                if (m_sof != (b == 0) || m_eol != (b % 8 == 7) || m_eof != (b == 63)) mark_bad++;
                if (m_pixel_data != 24'(beats + 256)) data_bad++;
                if (m_sof) sof_cnt++;
                if (m_eol) eol_cnt++;
                if (m_eof) begin
                    eof_cnt++;
                    eof_cyc = c;
                end
                beats++;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst          = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        frames_req    = 8'd0;
        s_pixel_valid = 1'b1;
        m_pixel_ready = 1'b1;
        s_pixel_data  = 24'h123456;

        // reset state while upstream offers data
        @(negedge clk); #1;
        check("rst_s_ready", s_pixel_ready, 0);
        check("rst_m_valid", m_pixel_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xy", {x_pos, y_pos}, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_markers", {m_sof, m_eol, m_eof}, 0);
        check("rst_data_pass", m_pixel_data, 24'h123456);
        @(negedge clk);
        nrst = 1'b1;

        // IDLE holds off upstream for 20 cycles
        begin
            int viol = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                s_pixel_valid = 1'b1;
                #1;
                if (s_pixel_ready || m_pixel_valid || busy) viol++;
            end
            check("idle_stall", viol, 0);
        end

        // two frames, full throughput
        do_start(8'd2);
        check("start_busy", busy, 1);
        check("start_frames_done", frames_done, 0);
        run(300, 1'b0, -1);
        check("f2_beats", beats, 128);
        check("f2_sof_cnt", sof_cnt, 2);
        check("f2_eof_cnt", eof_cnt, 2);
        check("f2_marker_pos", mark_bad, 0);
        check("f2_xy", pos_bad, 0);
        check("f2_done_width", done_cnt, 1);
        check("f2_done_latency", done_lat, 1);
        check("f2_done_gate", done_gate_bad, 0);
        check("f2_frames_done", frames_done, 2);
        check("f2_busy_after", busy, 0);

        // start and stop together is rejected; frames_done keeps its value
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        frames_req = 8'd5;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        s_pixel_valid = 1'b1;
        #1;
        check("startstop_busy", busy, 0);
        check("startstop_ready", s_pixel_ready, 0);
        check("startstop_frames_hold", frames_done, 2);

        // one frame under random valid/ready
        do_start(8'd1);
        run(3000, 1'b1, -1);
        check("rnd_beats", beats, 64);
        check("rnd_data_order", data_bad, 0);
        check("rnd_eol_cnt", eol_cnt, 8);
        check("rnd_markers", mark_bad, 0);
        check("rnd_xy", pos_bad, 0);
        check("rnd_done_width", done_cnt, 1);
        check("rnd_frames_done", frames_done, 1);

        // continuous, stop at beat 10 of the third frame drains to its end
        do_start(8'd0);
        run(400, 1'b0, 138);
        check("drain_beats", beats, 192);
        check("drain_frames_done", frames_done, 3);
        check("drain_done_width", done_cnt, 1);
        check("drain_done_latency", done_lat, 1);
        check("drain_markers", mark_bad, 0);

        // stop coinciding with the first eof ends immediately
        do_start(8'd0);
        run(200, 1'b0, 63);
        check("stopeof_beats", beats, 64);
        check("stopeof_frames_done", frames_done, 1);
        check("stopeof_done_latency", done_lat, 1);

        // reset in the middle of the second frame
        do_start(8'd0);
        run(94, 1'b0, -1);
        check("mid_beats", beats, 94);
        check("mid_frames_done", frames_done, 1);
        @(negedge clk);
        s_pixel_valid = 1'b1;
        nrst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gate", {s_pixel_ready, m_pixel_valid}, 0);
        check("mid_rst_xy", {x_pos, y_pos}, 0);
        check("mid_rst_frames_done", frames_done, 0);
        check("mid_rst_markers", {m_sof, m_eol, m_eof}, 0);
        @(negedge clk);
        nrst = 1'b1;
        do_start(8'd1);
        check("post_rst_frames_done", frames_done, 0);
        run(200, 1'b0, -1);
        check("post_rst_beats", beats, 64);
        check("post_rst_sof", sof_cnt, 1);
        check("post_rst_markers", mark_bad, 0);
        check("post_rst_frames_done_end", frames_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
